snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Top-level game sequencer for the snake/apple game. Owns the game state machine and the
//  snake move-tick timer. Latches the player's steering and tracks score and body length
//  from the apple module's add_cube pulse. Sits between the key debouncers and the
//  snake-body / apple / VGA blocks.
// PARAMETERS
//  TICK_INIT   12_500_000  cycles between move ticks at game start (0.25 s)
//  TICK_MIN     2_500_000  floor for move-tick period (SPEEDUP_EN only)
//  TICK_STEP      500_000  period decrement per apple eaten (SPEEDUP_EN only)
//  FLASH_HALF  12_500_000  cycles per flash half-period in DIE
//  DIE_FLASHES          8  flash_on toggles in DIE before restart
//  MAX_LEN             16  body length ceiling; reset length is 3
// PORTS
//  CLK_50M      in   1  50 MHz system clock
//  RSTn         in   1  asynchronous reset, active-low
//  key_start    in   1  debounced 1-cycle pulse, start game
//  key_dir      in   4  debounced 1-cycle pulses {right,left,down,up}
//  hit_wall     in   1  head on border cell (level, from body block)
//  hit_body     in   1  head on own body cell (level, from body block)
//  add_cube     in   1  apple eaten (pulse, from apple module)
//  game_status  out  2  0 RESTART, 1 START, 2 PLAY, 3 DIE
//  game_restart out  1  1-cycle pulse; clears body/apple blocks
//  move_tick    out  1  1-cycle pulse; body block advances one cell
//  direction    out  2  0 up, 1 down, 2 left, 3 right
//  cube_num     out  5  current body length, 3..MAX_LEN
//  score        out  8  apples eaten, saturating
//  flash_on     out  1  display enable; toggles in DIE, else 1
// BEHAVIOUR
//  Reset: game_status=RESTART, game_restart=0, move_tick=0, direction=3, cube_num=3,
//    score=0, flash_on=1; tick/flash counters=0, pending dir=3, period=TICK_INIT.
//  RESTART: for one cycle game_restart=1, score=0, cube_num=3, direction=3, period=TICK_INIT.
//    Next cycle -> START.
//  START: idle, no move_tick. key_start -> PLAY next cycle; tick counter cleared.
//  PLAY:
//   - tick counter counts 0..period-1; at period-1, move_tick=1 for 1 cycle and counter wraps.
//   - key_dir pulse loads the pending direction; multiple bits set -> lowest index wins.
//   - A request that reverses the current direction is ignored (up<->down, left<->right).
//   - direction <= pending in the same cycle move_tick asserts. Only the last accepted
//     request before a tick takes effect.
//   - add_cube: score +1 (hold at 255); cube_num +1 (hold at MAX_LEN).
//   - hit_wall|hit_body sampled every cycle -> DIE next cycle. Same cycle as add_cube:
//     collision wins, score/cube_num unchanged. No move_tick in the collision cycle.
//  DIE: flash counter counts FLASH_HALF cycles per half-period; toggles flash_on each time.
//   - After DIE_FLASHES toggles: flash_on=1 -> RESTART. Keys ignored in DIE.
//  key_start outside START: ignored.
//  RSTn low mid-game: immediate return to reset values; a pending tick is discarded.
//  Counters are 32-bit unsigned; period >= 2 is required of the parameters.
// CONFIGURATION
//  SPEEDUP_EN defined:
//   - Each accepted add_cube sets period <= max(period-TICK_STEP, TICK_MIN), computed with
//     no underflow.
//   - The new period applies from the next counter wrap.
//  SPEEDUP_EN undefined:
//   - period fixed at TICK_INIT.
//   - TICK_MIN/TICK_STEP are unused.
// TESTING  (bench params: TICK_INIT=20, TICK_MIN=8, TICK_STEP=4, FLASH_HALF=5, DIE_FLASHES=4)
//  1 Reset release: game_restart for 1 cycle; status 0->1; no move_tick for 100 cycles;
//    cube_num=3, direction=3.
//  2 key_start: status=2; move_tick exactly every 20 cycles; key_dir=4'b0001 (up) mid-period
//    -> direction=0 on the next tick edge; then down (4'b0010) -> direction stays 0.
//  3 Three add_cube pulses: score=3, cube_num=6. With SPEEDUP_EN tick spacing 20->16->12->8;
//    a 4th pulse keeps spacing 8. Without SPEEDUP_EN spacing stays 20.
//  4 hit_body in the same cycle as add_cube: status=3 next cycle; score/cube_num unchanged.
//    flash_on toggles every 5 cycles, 4 times; then RESTART pulse and START; score=0.
//  5 Saturation: 300 add_cube pulses -> score=255, cube_num=16.
//  6 RSTn low during PLAY mid-period: all outputs at reset values asynchronously; no stray
//    move_tick after release.

Source files
------------

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game sequencer and its neighbours (debouncers, body, apple, VGA).
// The master side drives keys and collision/apple events; the slave side is the sequencer.
interface snake_game_ctrl_if;
    logic       key_start;
    logic [3:0] key_dir;
    logic       hit_wall;
    logic       hit_body;
    logic       add_cube;
    logic [1:0] game_status;
    logic       game_restart;
    logic       move_tick;
    logic [1:0] direction;
    logic [4:0] cube_num;
    logic [7:0] score;
    logic       flash_on;

    modport master (
        output key_start, key_dir, hit_wall, hit_body, add_cube,
        input  game_status, game_restart, move_tick, direction, cube_num, score, flash_on
    );

    modport slave (
        input  key_start, key_dir, hit_wall, hit_body, add_cube,
        output game_status, game_restart, move_tick, direction, cube_num, score, flash_on
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game FSM, move-tick timer, steering latch, score and body length.
// Optional macro SPEEDUP_EN shortens the move-tick period with every apple eaten.
//
// state     | meaning
// S_RESTART | clear score/length/steering, issue one game_restart pulse
// S_START   | idle until key_start
// S_PLAY    | move ticks, steering, apples; any collision ends the game
// S_DIE     | flash the display DIE_FLASHES times, then restart
module snake_game_ctrl #(
    parameter int unsigned TICK_INIT   = 12_500_000,
    parameter int unsigned TICK_MIN    = 2_500_000,
    parameter int unsigned TICK_STEP   = 500_000,
    parameter int unsigned FLASH_HALF  = 12_500_000,
    parameter int unsigned DIE_FLASHES = 8,
    parameter int unsigned MAX_LEN     = 16
) (
    input  logic              CLK_50M,
    input  logic              RSTn,
    snake_game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_RESTART = 2'd0,
        S_START   = 2'd1,
        S_PLAY    = 2'd2,
        S_DIE     = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] period;
    logic [31:0] tick_cnt;
    logic [31:0] flash_cnt;
    logic [31:0] flash_num;
    logic [1:0]  dir_q, pend_q, req_dir;
    logic [4:0]  cube_q;
    logic [7:0]  score_q;
    logic        restart_q, flash_q;
    logic        collide, tick_hit, flash_wrap, die_done, req_valid, req_ok;

    assign collide    = bus.hit_wall | bus.hit_body;
    assign tick_hit   = (state == S_PLAY) && (tick_cnt == period - 32'd1);
    assign flash_wrap = (state == S_DIE) && (flash_cnt == FLASH_HALF - 32'd1);
    assign die_done   = flash_wrap && (flash_num == DIE_FLASHES - 32'd1);

    always_comb begin
        req_valid = |bus.key_dir;
        req_dir   = 2'd0;
        if (bus.key_dir[0])      req_dir = 2'd0;
        else if (bus.key_dir[1]) req_dir = 2'd1;
        else if (bus.key_dir[2]) req_dir = 2'd2;
        else if (bus.key_dir[3]) req_dir = 2'd3;
    end

    // Opposite directions differ only in bit 0 (up/down = 0/1, left/right = 2/3).
    assign req_ok = req_valid && ((req_dir ^ dir_q) != 2'd1);

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) state <= S_RESTART;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESTART: if (restart_q)     state_nxt = S_START;
            S_START:   if (bus.key_start) state_nxt = S_PLAY;
            S_PLAY:    if (collide)       state_nxt = S_DIE;
            S_DIE:     if (die_done)      state_nxt = S_RESTART;
            default:                      state_nxt = S_RESTART;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            restart_q <= 1'b0;
            tick_cnt  <= 32'd0;
            flash_cnt <= 32'd0;
            flash_num <= 32'd0;
            flash_q   <= 1'b1;
            dir_q     <= 2'd3;
            pend_q    <= 2'd3;
            cube_q    <= 5'd3;
            score_q   <= 8'd0;
        end else begin
            restart_q <= (state == S_RESTART) && !restart_q;
            case (state)
                S_RESTART: begin
                    score_q <= 8'd0;
                    cube_q  <= 5'd3;
                    dir_q   <= 2'd3;
                    pend_q  <= 2'd3;
                    flash_q <= 1'b1;
                end
                S_START: tick_cnt <= 32'd0;
                S_PLAY: begin
                    if (collide) begin
                        flash_cnt <= 32'd0;
                        flash_num <= 32'd0;
                    end else begin
                        tick_cnt <= tick_hit ? 32'd0 : tick_cnt + 32'd1;
                        if (tick_hit) dir_q  <= pend_q;
                        if (req_ok)   pend_q <= req_dir;
                        if (bus.add_cube) begin
                            if (score_q != 8'hFF)       score_q <= score_q + 8'd1;
                            if (cube_q != 5'(MAX_LEN))  cube_q  <= cube_q + 5'd1;
                        end
                    end
                end
                S_DIE: begin
                    if (flash_wrap) begin
                        flash_cnt <= 32'd0;
                        flash_num <= flash_num + 32'd1;
                        flash_q   <= die_done ? 1'b1 : ~flash_q;
                    end else begin
                        flash_cnt <= flash_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPEEDUP_EN
    logic [31:0] period_q, period_pend, period_dec;

    assign period     = period_q;
    assign period_dec = (period_pend >= TICK_MIN + TICK_STEP) ? period_pend - TICK_STEP : TICK_MIN;

    // The shortened period is staged and only loaded into the live compare at a wrap.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            period_q    <= TICK_INIT;
            period_pend <= TICK_INIT;
        end else if (state == S_RESTART) begin
            period_q    <= TICK_INIT;
            period_pend <= TICK_INIT;
        end else if (state == S_PLAY && !collide) begin
            if (tick_hit)     period_q    <= period_pend;
            if (bus.add_cube) period_pend <= period_dec;
        end
    end
`else
    logic unused_speedup;

    assign period         = TICK_INIT;
    assign unused_speedup = ^{TICK_MIN, TICK_STEP};
`endif

    assign bus.game_status  = state;
    assign bus.game_restart = restart_q;
    assign bus.move_tick    = tick_hit && !collide;
    assign bus.direction    = dir_q;
    assign bus.cube_num     = cube_q;
    assign bus.score        = score_q;
    assign bus.flash_on     = flash_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: a cycle-level game model checked against the DUT every cycle,
// plus directed scenarios with literal expectations and a randomized play phase.
module tb_snake_game_ctrl;
    localparam int TI = 20;
    localparam int TM = 8;
    localparam int TS = 4;
    localparam int FH = 5;
    localparam int DF = 4;
    localparam int ML = 16;

    logic CLK_50M = 1'b0;
    logic RSTn    = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .TICK_INIT(TI), .TICK_MIN(TM), .TICK_STEP(TS),
        .FLASH_HALF(FH), .DIE_FLASHES(DF), .MAX_LEN(ML)
    ) dut (
        .CLK_50M(CLK_50M),
        .RSTn(RSTn),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // game model: phase, age within phase, cycles since last wrap, steering, counts
    int m_st = 0, m_age = 0, m_since = 0, m_per = TI, m_pnext = TI;
    int m_dir = 3, m_pend = 3, m_cube = 3, m_score = 0;

    // observation bookkeeping, written only by the compare process
    int cyc = 0, n_tick = 0, n_restart = 0, n_flip = 0, last_tick = -1, last_gap = 0;
    int prev_st = 0;
    logic prev_fl = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int low_bit(input logic [3:0] k);
        for (int i = 0; i < 4; i++) if (k[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_age = 0; m_since = 0; m_per = TI; m_pnext = TI;
        m_dir = 3; m_pend = 3; m_cube = 3; m_score = 0;
    endtask

    always @(negedge CLK_50M) begin
        int e_tick, e_gr, e_fl, req, od;
        if (!RSTn) model_reset();
        e_gr   = (m_st == 0 && m_age == 1) ? 1 : 0;
        e_tick = (m_st == 2 && m_since == m_per - 1 && !(bus.hit_wall || bus.hit_body)) ? 1 : 0;
        e_fl   = (m_st == 3) ? ((((m_age / FH) % 2) == 0) ? 1 : 0) : 1;
        chk("status",    int'(bus.game_status),  m_st);
        chk("restart",   int'(bus.game_restart), e_gr);
        chk("move_tick", int'(bus.move_tick),    e_tick);
        chk("direction", int'(bus.direction),    m_dir);
        chk("cube_num",  int'(bus.cube_num),     m_cube);
        chk("score",     int'(bus.score),        m_score);
        chk("flash_on",  int'(bus.flash_on),     e_fl);

        cyc++;
        if (RSTn && bus.game_restart) n_restart++;
        if (bus.move_tick) begin
            n_tick++;
            if (last_tick >= 0) last_gap = cyc - last_tick;
            last_tick = cyc;
        end
        if (!RSTn || bus.game_status != 2'd2) last_tick = -1;
        if (prev_st == 3 && bus.flash_on != prev_fl) n_flip++;
        prev_st = int'(bus.game_status);
        prev_fl = bus.flash_on;

        if (RSTn) begin
            case (m_st)
                0: begin
                    m_score = 0; m_cube = 3; m_dir = 3; m_pend = 3; m_per = TI; m_pnext = TI;
                    if (m_age == 1) begin m_st = 1; m_age = 0; end
                    else m_age++;
                end
                1: if (bus.key_start) begin m_st = 2; m_since = 0; end
                2: begin
                    if (bus.hit_wall || bus.hit_body) begin
                        m_st = 3; m_age = 0;
                    end else begin
                        od  = m_dir;
                        req = low_bit(bus.key_dir);
                        if (e_tick == 1) begin m_dir = m_pend; m_since = 0; m_per = m_pnext; end
                        else m_since++;
                        if (req >= 0 && req != opp(od)) m_pend = req;
                        if (bus.add_cube) begin
                            if (m_score < 255) m_score++;
                            if (m_cube < ML) m_cube++;
`ifdef SPEEDUP_EN
                            m_pnext = (m_pnext >= TM + TS) ? m_pnext - TS : TM;
`endif
                        end
                    end
                end
                default: begin
                    m_age++;
                    if (m_age == FH * DF) begin m_st = 0; m_age = 0; end
                end
            endcase
        end
    end

    task automatic next(input int n);
        repeat (n) @(posedge CLK_50M);
        #1;
    endtask

    task automatic press_start();
        bus.key_start = 1'b1; next(1); bus.key_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t0, f0, r0, exp_gap;
        bus.key_start = 1'b0; bus.key_dir = 4'b0; bus.hit_wall = 1'b0;
        bus.hit_body  = 1'b0; bus.add_cube = 1'b0;

        // reset release, then idle in START
        next(3);
        RSTn = 1'b1;
        next(100);
        chk("t1_restart_pulses", n_restart, 1);
        chk("t1_idle_ticks", n_tick, 0);
        chk("t1_status", int'(bus.game_status), 1);
        chk("t1_cube", int'(bus.cube_num), 3);
        chk("t1_dir", int'(bus.direction), 3);

        // play, steering and reversal rejection
        press_start();
        chk("t2_status", int'(bus.game_status), 2);
        next(10);
        bus.key_dir = 4'b0001; next(1); bus.key_dir = 4'b0;
        next(70);
        chk("t2_gap", last_gap, 20);
        chk("t2_dir_up", int'(bus.direction), 0);
        bus.key_dir = 4'b0010; next(1); bus.key_dir = 4'b0;
        next(25);
        chk("t2_dir_kept", int'(bus.direction), 0);

        // apples and tick spacing
        for (int k = 0; k < 4; k++) begin
            bus.add_cube = 1'b1; next(1); bus.add_cube = 1'b0;
            next(40);
`ifdef SPEEDUP_EN
            exp_gap = (k < 3) ? 16 - 4 * k : 8;
`else
            exp_gap = 20;
`endif
            chk("t3_gap", last_gap, exp_gap);
            if (k == 2) begin
                chk("t3_score", int'(bus.score), 3);
                chk("t3_cube", int'(bus.cube_num), 6);
            end
        end

        // collision beats apple, flash sequence, restart
        r0 = n_restart; f0 = n_flip;
        bus.hit_body = 1'b1; bus.add_cube = 1'b1; next(1);
        bus.hit_body = 1'b0; bus.add_cube = 1'b0;
        chk("t4_status_die", int'(bus.game_status), 3);
        chk("t4_score_kept", int'(bus.score), 4);
        chk("t4_cube_kept", int'(bus.cube_num), 7);
        next(30);
        chk("t4_flips", n_flip - f0, 4);
        chk("t4_restart", n_restart - r0, 1);
        chk("t4_status_start", int'(bus.game_status), 1);
        chk("t4_score_clr", int'(bus.score), 0);
        chk("t4_flash", int'(bus.flash_on), 1);

        // saturation
        press_start();
        for (int i = 0; i < 300; i++) begin
            bus.add_cube = 1'b1;
            bus.key_dir  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            next(1);
            bus.add_cube = 1'b0; bus.key_dir = 4'b0;
            next($urandom_range(1, 3));
        end
        chk("t5_score", int'(bus.score), 255);
        chk("t5_cube", int'(bus.cube_num), 16);

        // asynchronous reset mid-period
        next(7);
        #2 RSTn = 1'b0;
        #1;
        chk("t6_status", int'(bus.game_status), 0);
        chk("t6_restart", int'(bus.game_restart), 0);
        chk("t6_tick", int'(bus.move_tick), 0);
        chk("t6_dir", int'(bus.direction), 3);
        chk("t6_cube", int'(bus.cube_num), 3);
        chk("t6_score", int'(bus.score), 0);
        chk("t6_flash", int'(bus.flash_on), 1);
        next(2);
        RSTn = 1'b1;
        t0 = n_tick;
        next(100);
        chk("t6_no_stray_tick", n_tick - t0, 0);
        chk("t6_status_start", int'(bus.game_status), 1);

        // randomized play across all phases
        for (int i = 0; i < 1500; i++) begin
            bus.key_start = ($urandom_range(0, 15) == 0);
            bus.key_dir   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            bus.add_cube  = ($urandom_range(0, 9) == 0);
            bus.hit_wall  = ($urandom_range(0, 249) == 0);
            bus.hit_body  = ($urandom_range(0, 399) == 0);
            next(1);
        end
        bus.key_start = 1'b0; bus.key_dir = 4'b0; bus.add_cube = 1'b0;
        bus.hit_wall  = 1'b0; bus.hit_body = 1'b0;
        next(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
